// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared types and constants for the alarm clock control path
package alarm_clock_pkg;

    // Keypad code width, shared with the key buffer and the LCD driver
    localparam int KEY_W = 4;

    // Keypad code meaning "no key pressed"; 0-9 are digits
    localparam logic [KEY_W-1:0] NOKEY_DEFAULT = 4'hA;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAITED = 3'd2,
        KEY_ENTRY  = 3'd3,
        SHOW_ALARM = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/alarm_clock_fsm_if.sv
// rtl/alarm_clock_fsm_if.sv - keypad/button inputs and display/strobe outputs of the alarm clock FSM
interface alarm_clock_fsm_if;

    logic                             one_second;
    logic [alarm_clock_pkg::KEY_W-1:0] key;
    logic                             alarm_button;
    logic                             time_button;
    logic                             show_new_time;
    logic                             show_alarm;
    logic                             shift;
    logic                             load_new_a;
    logic                             load_new_c;

    // Stimulus side: drives the keypad, buttons and seconds tick
    modport master (
        output one_second, key, alarm_button, time_button,
        input  show_new_time, show_alarm, shift, load_new_a, load_new_c
    );

    // FSM side
    modport slave (
        input  one_second, key, alarm_button, time_button,
        output show_new_time, show_alarm, shift, load_new_a, load_new_c
    );

endinterface

// File: rtl/alarm_timeout_counter.sv
// rtl/alarm_timeout_counter.sv - keypad inactivity counter in one_second ticks
module alarm_timeout_counter #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic one_second,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_SEC - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TIMEOUT_SEC);

    logic [CNT_W-1:0] r_count;
    logic             w_tick;

    assign w_tick  = enable && one_second;
    assign timeout = w_tick && (r_count == LAST);

    // Count ticks while enabled; clear wins, and the count saturates instead of wrapping
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (w_tick && (r_count != FULL)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_clock_fsm.sv
// rtl/alarm_clock_fsm.sv - alarm clock control FSM: key entry sequencing, display select and load strobes
module alarm_clock_fsm
    import alarm_clock_pkg::*;
#(
    parameter int               TIMEOUT_SEC = 10,
    parameter logic [KEY_W-1:0] NOKEY       = NOKEY_DEFAULT
) (
    input logic              clock,
    input logic              reset,
    alarm_clock_fsm_if.slave bus
);

    fsm_state_t r_state;
    fsm_state_t w_next_state;
    logic       r_load_a;
    logic       r_load_c;
    logic       w_load_a;
    logic       w_load_c;
    logic       w_key_pressed;
    logic       w_timeout;
    logic       w_cnt_clear;
    logic       w_cnt_enable;

    assign w_key_pressed = (bus.key != NOKEY);

    // Inactivity is only timed while an entry is in progress
    assign w_cnt_enable = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);
    // Every new key and every return to the time display restarts the timeout
    assign w_cnt_clear  = (w_next_state == KEY_STORED) || (w_next_state == SHOW_TIME);

    alarm_timeout_counter #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_cnt_clear),
        .enable     (w_cnt_enable),
        .one_second (bus.one_second),
        .timeout    (w_timeout)
    );

    // State register plus load strobes, which last for the first SHOW_TIME cycle only
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= SHOW_TIME;
            r_load_a <= 1'b0;
            r_load_c <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_load_a <= w_load_a;
            r_load_c <= w_load_c;
        end
    end

    // Next-state selection; buttons and keys take priority over a coincident timeout
    always_comb begin
        w_next_state = r_state;
        w_load_a     = 1'b0;
        w_load_c     = 1'b0;
        case (r_state)
            SHOW_TIME: begin
                if (bus.alarm_button) begin
                    w_next_state = SHOW_ALARM;
                end else if (w_key_pressed) begin
                    w_next_state = KEY_STORED;
                end
            end
            KEY_STORED: begin
                w_next_state = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (!w_key_pressed) begin
                    w_next_state = KEY_ENTRY;
                end else if (w_timeout) begin
                    w_next_state = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (bus.alarm_button) begin
                    w_next_state = SHOW_TIME;
                    w_load_a     = 1'b1;
                end else if (bus.time_button) begin
                    w_next_state = SHOW_TIME;
                    w_load_c     = 1'b1;
                end else if (w_key_pressed) begin
                    w_next_state = KEY_STORED;
                end else if (w_timeout) begin
                    w_next_state = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button) begin
                    w_next_state = SHOW_TIME;
                end
            end
            default: begin
                w_next_state = SHOW_TIME;
            end
        endcase
    end

    // Moore decode of the state register; nothing here depends on the inputs
    assign bus.show_new_time = (r_state == KEY_STORED) || (r_state == KEY_WAITED) ||
                               (r_state == KEY_ENTRY);
    assign bus.show_alarm    = (r_state == SHOW_ALARM);
    assign bus.shift         = (r_state == KEY_STORED);
    assign bus.load_new_a    = r_load_a;
    assign bus.load_new_c    = r_load_c;

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// tb/tb_alarm_clock_fsm.sv - self-checking bench for alarm_clock_fsm against a behavioural model
module tb_alarm_clock_fsm;

    localparam int         TO = 10;
    localparam logic [3:0] NK = 4'hA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alarm_clock_fsm_if u_if ();

    alarm_clock_fsm #(
        .TIMEOUT_SEC (TO),
        .NOKEY       (NK)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (u_if)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: an entry session with a pending-press flag, a release flag and an idle-second count
    bit m_entry, m_alarm_view, m_pressed, m_released, m_load_a, m_load_c;
    int m_idle;

    task automatic model_step();
        bit kp;
        bit tick;
        kp   = (u_if.key != NK);
        tick = u_if.one_second;
        m_load_a = 1'b0;
        m_load_c = 1'b0;
        if (rst) begin
            m_entry = 0; m_alarm_view = 0; m_pressed = 0; m_released = 0; m_idle = 0;
        end else if (m_alarm_view) begin
            m_alarm_view = u_if.alarm_button;
        end else if (!m_entry) begin
            if (u_if.alarm_button) m_alarm_view = 1;
            else if (kp) begin m_entry = 1; m_pressed = 1; m_released = 0; m_idle = 0; end
        end else if (m_pressed) begin
            m_pressed = 0;
        end else if (!m_released) begin
            if (!kp) begin
                m_released = 1;
                if (tick && m_idle < TO) m_idle++;
            end else if (tick) begin
                if (m_idle == TO - 1) m_entry = 0;
                if (m_idle < TO) m_idle++;
            end
        end else begin
            if (u_if.alarm_button) begin m_entry = 0; m_load_a = 1; end
            else if (u_if.time_button) begin m_entry = 0; m_load_c = 1; end
            else if (kp) begin m_pressed = 1; m_released = 0; m_idle = 0; end
            else if (tick) begin
                if (m_idle == TO - 1) m_entry = 0;
                if (m_idle < TO) m_idle++;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] k, input logic a, input logic t, input logic s);
        rst               = r;
        u_if.key          = k;
        u_if.alarm_button = a;
        u_if.time_button  = t;
        u_if.one_second   = s;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [4:0] dut_out();
        return {u_if.show_new_time, u_if.show_alarm, u_if.shift, u_if.load_new_a, u_if.load_new_c};
    endfunction

    function automatic logic [4:0] exp_out();
        return {m_entry, m_alarm_view, m_pressed, m_load_a, m_load_c};
    endfunction

    task automatic test_reset();
        drive(1, NK, 0, 0, 0);
        cyc(); cyc();
        tests++;
        if (dut_out() !== 5'b00000) begin
            fails++; $display("FAIL reset_outputs got=%b exp=%b", dut_out(), 5'b00000);
        end
        drive(0, NK, 0, 0, 0);
        for (int sec = 0; sec < 20; sec++) begin
            for (int c = 0; c < 4; c++) begin
                u_if.one_second = (c == 0);
                cyc();
                tests++;
                if (dut_out() !== 5'b00000 || exp_out() !== 5'b00000) begin
                    fails++; $display("FAIL idle_show_time sec=%0d got=%b exp=%b", sec, dut_out(), 5'b00000);
                end
            end
        end
    endtask

    task automatic test_entry_time();
        int  n_shift = 0, n_la = 0, n_lc = 0, snt_gaps = 0;
        bit  seen = 0;
        for (int d = 1; d <= 4; d++) begin
            for (int c = 0; c < 8; c++) begin
                drive(0, (c < 3) ? 4'(d) : NK, 0, 0, 0);
                cyc();
                tests++;
                if (dut_out() !== exp_out()) begin
                    fails++; $display("FAIL entry_digit d=%0d c=%0d got=%b exp=%b", d, c, dut_out(), exp_out());
                end
                if (u_if.shift) begin n_shift++; seen = 1; end
                if (seen && !u_if.show_new_time) snt_gaps++;
                n_la += int'(u_if.load_new_a);
                n_lc += int'(u_if.load_new_c);
            end
        end
        drive(0, NK, 0, 1, 0);
        cyc();
        tests++;
        if ({u_if.show_new_time, u_if.load_new_c, u_if.load_new_a} !== 3'b010) begin
            fails++; $display("FAIL time_button_edge got=%b exp=%b",
                              {u_if.show_new_time, u_if.load_new_c, u_if.load_new_a}, 3'b010);
        end
        n_la += int'(u_if.load_new_a);
        n_lc += int'(u_if.load_new_c);
        drive(0, NK, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            tests++;
            if (dut_out() !== exp_out()) begin
                fails++; $display("FAIL entry_after c=%0d got=%b exp=%b", c, dut_out(), exp_out());
            end
            n_la += int'(u_if.load_new_a);
            n_lc += int'(u_if.load_new_c);
        end
        tests++;
        if (n_shift != 4) begin fails++; $display("FAIL shift_count got=%0d exp=4", n_shift); end
        tests++;
        if (snt_gaps != 0) begin fails++; $display("FAIL show_new_time_gaps got=%0d exp=0", snt_gaps); end
        tests++;
        if (n_lc != 1 || n_la != 0) begin
            fails++; $display("FAIL load_counts got=c%0d/a%0d exp=c1/a0", n_lc, n_la);
        end
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 4; c++) begin
            drive(0, (c < 2) ? 4'h5 : NK, 0, 0, 0);
            cyc();
        end
        for (int t = 1; t <= TO; t++) begin
            drive(0, NK, 0, 0, 1);
            cyc();
            tests++;
            if (dut_out() !== exp_out()) begin
                fails++; $display("FAIL timeout_tick t=%0d got=%b exp=%b", t, dut_out(), exp_out());
            end
            if (t == TO - 1) begin
                tests++;
                if (u_if.show_new_time !== 1'b1) begin
                    fails++; $display("FAIL before_timeout got=%b exp=1", u_if.show_new_time);
                end
            end
            if (t == TO) begin
                tests++;
                if ({u_if.show_new_time, u_if.load_new_a, u_if.load_new_c} !== 3'b000) begin
                    fails++; $display("FAIL at_timeout got=%b exp=000",
                                      {u_if.show_new_time, u_if.load_new_a, u_if.load_new_c});
                end
            end
            drive(0, NK, 0, 0, 0);
            cyc(); cyc();
        end
    endtask

    task automatic test_both_buttons();
        for (int c = 0; c < 4; c++) begin
            drive(0, (c < 2) ? 4'h3 : NK, 0, 0, 0);
            cyc();
        end
        drive(0, NK, 1, 1, 0);
        cyc();
        tests++;
        if (dut_out() !== 5'b00010) begin
            fails++; $display("FAIL both_buttons got=%b exp=%b", dut_out(), 5'b00010);
        end
        drive(0, NK, 0, 0, 0);
        cyc();
        tests++;
        if (dut_out() !== 5'b00000) begin
            fails++; $display("FAIL both_buttons_after got=%b exp=%b", dut_out(), 5'b00000);
        end
    endtask

    task automatic test_alarm_hold();
        int n_alarm = 0, n_shift = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 5) drive(0, 4'h7, 1, 0, 0);
            else       drive(0, NK, 0, 0, 0);
            cyc();
            tests++;
            if (dut_out() !== exp_out()) begin
                fails++; $display("FAIL alarm_hold c=%0d got=%b exp=%b", c, dut_out(), exp_out());
            end
            n_alarm += int'(u_if.show_alarm);
            n_shift += int'(u_if.shift);
        end
        tests++;
        if (n_alarm != 5 || n_shift != 0) begin
            fails++; $display("FAIL alarm_hold_counts got=alarm%0d/shift%0d exp=alarm5/shift0", n_alarm, n_shift);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 4'h8, 0, 0, 0);
        cyc(); cyc();
        drive(1, 4'h8, 0, 0, 0);
        cyc();
        tests++;
        if (dut_out() !== 5'b00000) begin
            fails++; $display("FAIL reset_in_waited got=%b exp=%b", dut_out(), 5'b00000);
        end
        drive(0, NK, 0, 0, 0);
        cyc();
        drive(0, NK, 0, 1, 0);
        cyc();
        tests++;
        if (dut_out() !== 5'b00000) begin
            fails++; $display("FAIL time_after_reset got=%b exp=%b", dut_out(), 5'b00000);
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, (c < 2) ? 4'h1 : NK, 0, 0, 0);
            cyc();
        end
        drive(1, NK, 0, 1, 0);
        cyc();
        drive(0, NK, 0, 0, 0);
        cyc();
        tests++;
        if (dut_out() !== 5'b00000) begin
            fails++; $display("FAIL pending_load_reset got=%b exp=%b", dut_out(), 5'b00000);
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        k = NK;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 6) k = ($urandom_range(1) == 0) ? NK : 4'($urandom_range(9));
            drive(($urandom_range(499) == 0), k, ($urandom_range(99) < 4), ($urandom_range(99) < 4),
                  ($urandom_range(99) < 30));
            cyc();
            tests++;
            if (dut_out() !== exp_out()) begin
                fails++; $display("FAIL random i=%0d got=%b exp=%b", i, dut_out(), exp_out());
            end
        end
    endtask

    initial begin
        drive(1, NK, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_entry_time();
        test_timeout();
        test_both_buttons();
        test_alarm_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
